// File: rtl/board_pkg.sv
// Shared board-level types for button and input conditioning.
// Imported by the debouncer and its wrappers.
package board_pkg;

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } debounce_state_t;

    localparam int DEBOUNCE_SYNC_DEF = 2;

endpackage

// File: rtl/btn_debounce_if.sv
// Button pin, tick enable and debounced outputs of one button.
// master drives the raw inputs; slave is the debouncer.
interface btn_debounce_if;

    logic tickI;
    logic btnI;
    logic btnO;
    logic pressO;
    logic releaseO;
    logic busyO;

    modport master (
        output tickI,
        output btnI,
        input  btnO,
        input  pressO,
        input  releaseO,
        input  busyO
    );

    modport slave (
        input  tickI,
        input  btnI,
        output btnO,
        output pressO,
        output releaseO,
        output busyO
    );

endinterface

// File: rtl/sync_ff.sv
// Generic multi-flop synchroniser with synchronous reset.
// Shared by all asynchronous board inputs.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clkI,
    input  logic rstI,
    input  logic dI,
    output logic qO
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the pin one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], dI};
    end

    // Chain flops; reset to the idle pin level.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign qO = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer qualified by the slow divider tick.
// Emits a clean level plus one-cycle press/release pulses.
module btn_debounce
    import board_pkg::*;
#(
    parameter int STABLE_TICKS = 20,
    parameter int SYNC_STAGES  = DEBOUNCE_SYNC_DEF,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic     clkI,
    input  logic     rstI,
    btn_debounce_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic PIN_IDLE = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(STABLE_TICKS - 1);

    logic            btn_sync;
    logic            pressed_s;
    logic            tick_q;
    logic            tick_d;
    logic            tick_rise;
    debounce_state_t state_q;
    debounce_state_t state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic            btn_q;
    logic            btn_d;
    logic            press_q;
    logic            press_d;
    logic            release_q;
    logic            release_d;
    logic            busy_q;
    logic            busy_d;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (PIN_IDLE)
    ) u_sync (
        .clkI (clkI),
        .rstI (rstI),
        .dI   (bus.btnI),
        .qO   (btn_sync)
    );

    // Idle pin level maps to released whatever the polarity.
    assign pressed_s = btn_sync ^ PIN_IDLE;

    // tickI is only a level; a rise is one clkI cycle wide.
    assign tick_d    = bus.tickI;
    assign tick_rise = bus.tickI & ~tick_q;

    // Tick history; resets high so reset exit is not a tick.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            tick_q <= 1'b1;
        end else begin
            tick_q <= tick_d;
        end
    end

    // Next state, counter and output pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        btn_d     = btn_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            S_RELEASED: begin
                if (pressed_s) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                end else if (tick_rise) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                        btn_d   = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PRESSED: begin
                if (!pressed_s) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else if (tick_rise) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_RELEASED;
                        cnt_d     = '0;
                        btn_d     = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
        busy_d = (state_d == S_PRESS_WAIT) ||
                 (state_d == S_RELEASE_WAIT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            state_q   <= S_RELEASED;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.btnO     = btn_q;
    assign bus.pressO   = press_q;
    assign bus.releaseO = release_q;
    assign bus.busyO    = busy_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: vector table for levels,
// pulse scoreboard keyed on the expected clkI cycle.
module tb_btn_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_debounce_if bus ();

    btn_debounce #(
        .STABLE_TICKS (4),
        .SYNC_STAGES  (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .clkI (clk),
        .rstI (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_press;
        int cyc;
    } exp_t;

    typedef struct {
        logic btn;
        int   hold;
        logic exp_btn;
        logic exp_busy;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   cyc      = 0;
    int   n_chk    = 0;
    int   n_fail   = 0;
    bit   tick_run = 1'b1;

    task automatic chk(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Posedge index of the k-th tick rise after cycle 'after'.
    // Ticks rise at posedges where index % 10 == 5.
    function automatic int kth_rise(int after, int k);
        int n = after + 1;
        while ((n % 10) != 5) n++;
        return n + 10 * (k - 1);
    endfunction

    task automatic push(bit is_press, int when);
        exp_t e;
        e.is_press = is_press;
        e.cyc      = when;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missed_pulse", 32'(cyc), 32'(e.cyc));
        end
        if (bus.pressO || bus.releaseO) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse",
                    {bus.pressO, bus.releaseO}, 0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind",
                    {bus.pressO, bus.releaseO},
                    e.is_press ? 2'b10 : 2'b01);
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("pulse_level", bus.btnO, e.is_press);
            end
        end
    endtask

    task automatic step();
        bus.tickI = tick_run && (((cyc + 1) % 10) >= 5);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    // Next posedge will have index % 10 == 0.
    task automatic align();
        while (((cyc + 1) % 10) != 0) step();
    endtask

    task automatic drain();
        int b = 300;
        while (sb.size() != 0 && b > 0) begin
            step();
            b--;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic set_btn(logic v);
        if (v != bus.btnI) begin
            push(v == 1'b0, kth_rise(cyc + 3, 4));
        end
        bus.btnI = v;
    endtask

    initial begin
        vecs[0] = '{1'b0, 3,  1'b0, 1'b1};
        vecs[1] = '{1'b0, 31, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 2,  1'b1, 1'b0};
        vecs[3] = '{1'b0, 14, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 3,  1'b1, 1'b1};
        vecs[5] = '{1'b1, 31, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 2,  1'b0, 1'b0};
        vecs[7] = '{1'b1, 14, 1'b0, 1'b0};

        bus.btnI  = 1'b1;
        bus.tickI = 1'b0;

        // Reset held with the button idle.
        rst = 1'b1;
        repeat (100) begin
            step();
            chk("reset_outs",
                {bus.btnO, bus.pressO,
                 bus.releaseO, bus.busyO}, 0);
        end
        rst = 1'b0;
        repeat (20) step();
        chk("idle_after_reset",
            {bus.btnO, bus.busyO}, 0);

        // Clean press then clean release.
        align();
        foreach (vecs[i]) begin
            set_btn(vecs[i].btn);
            repeat (vecs[i].hold) step();
            chk($sformatf("vec%0d", i),
                {bus.btnO, bus.busyO},
                {vecs[i].exp_btn, vecs[i].exp_busy});
        end
        drain();

        // Bounce after two ticks is rejected.
        align();
        bus.btnI = 1'b0;
        repeat (20) step();
        bus.btnI = 1'b1;
        step();
        bus.btnI = 1'b0;
        step();
        step();
        chk("glitch_abort",
            {bus.btnO, bus.busyO}, 0);
        step();
        chk("glitch_rearm", bus.busyO, 1);
        push(1'b1, kth_rise(cyc, 4));
        drain();
        align();
        set_btn(1'b1);
        drain();

        // Reset mid-qualification, button held.
        align();
        bus.btnI = 1'b0;
        repeat (17) step();
        rst = 1'b1;
        step();
        chk("mid_reset",
            {bus.btnO, bus.pressO,
             bus.releaseO, bus.busyO}, 0);
        rst = 1'b0;
        push(1'b1, kth_rise(cyc + 3, 4));
        drain();
        chk("after_reset_press", bus.btnO, 1);
        align();
        set_btn(1'b1);
        drain();

        // Tick stalls: waiting forever, then resumes.
        tick_run = 1'b0;
        step();
        bus.btnI = 1'b0;
        repeat (200) step();
        chk("stall_wait",
            {bus.btnO, bus.busyO}, 2'b01);
        align();
        tick_run = 1'b1;
        push(1'b1, kth_rise(cyc, 4));
        drain();
        chk("resume_press",
            {bus.btnO, bus.busyO}, 2'b10);

        repeat (20) step();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
